rx_deframer: RTL and testbench

- RX-side counterpart of the TX framing path. Strips the 2-byte framing token at the head of each TLP and realigns the payload into lane 0 onward.
- Holds the trailing 2 bytes of each input word in an internal 2-byte realignment register.
- Flushes the residue after end of TLP.
- Sits between the RX lane-deskew/byte-unstriping stage and the RX TLP buffer.

---
 rtl/rx_deframe_pkg.sv | 17 +
 rtl/rx_deframe_hold_reg.sv | 24 ++
 rtl/rx_deframer.sv | 198 +++++++++++++++++++
 tb/tb_rx_deframer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rx_deframe_pkg.sv
// rtl/rx_deframe_pkg.sv - shared state encoding and framing token layout for rx_deframer
package rx_deframe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STRIP = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int TOKEN_BYTES = 2;

    // Length field in DW, big-endian bit numbering over the 16-bit token
    localparam int TOK_LEN_LO = 4;
    localparam int TOK_LEN_HI = 14;
    localparam int TOK_LEN_W  = TOK_LEN_HI - TOK_LEN_LO + 1;

endpackage

// File: rtl/rx_deframe_hold_reg.sv
// rtl/rx_deframe_hold_reg.sv - 2-byte write-enabled realignment register with async clear
module rx_deframe_hold_reg #(
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [0:2*SYMBOL_WIDTH-1] d_i,
    output logic [0:2*SYMBOL_WIDTH-1] q_o
);

    logic [0:2*SYMBOL_WIDTH-1] hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (we_i) begin
            hold_q <= d_i;
        end
    end

    assign q_o = hold_q;

endmodule

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - strips the 2-byte framing token and realigns TLP payload to lane 0
// Optional TLP length check against the token is enabled by RX_DEFRAME_LEN_CHK_EN.
module rx_deframer
    import rx_deframe_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 8,
    parameter int LANES        = 4,
    parameter int DATA_WIDTH   = SYMBOL_WIDTH * LANES,
    parameter int CNT_WIDTH    = $clog2(LANES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_L,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    input  logic [0:DATA_WIDTH-1] i_data,
    input  logic                  i_sot,
    input  logic                  i_eot,
    input  logic [CNT_WIDTH-1:0]  i_eot_bytes,
    output logic                  o_valid,
    output logic [0:DATA_WIDTH-1] o_data,
    output logic                  o_sot,
    output logic                  o_eot,
    output logic [CNT_WIDTH-1:0]  o_eot_bytes,
    output logic                  o_frm_err
);

    localparam int HW = TOKEN_BYTES * SYMBOL_WIDTH;

    state_e                state_q, state_d;
    logic                  sot_pend_q, sot_pend_d;
    logic [CNT_WIDTH-1:0]  flush_n_q, flush_n_d;
    logic                  o_valid_q, o_valid_d;
    logic [0:DATA_WIDTH-1] o_data_q, o_data_d;
    logic                  o_sot_q, o_sot_d;
    logic                  o_eot_q, o_eot_d;
    logic [CNT_WIDTH-1:0]  o_eot_bytes_q, o_eot_bytes_d;
    logic                  o_frm_err_q, frm_err_d;
    logic                  o_in_ready_q, o_in_ready_d;
    logic                  hold_we;
    logic [0:HW-1]         hold_q;
    logic                  accept, len_err;
    int                    eot_n;
    logic [0:DATA_WIDTH-1] strip_word, sot_word, flush_word;

    function automatic logic [0:DATA_WIDTH-1] keep_bytes(input logic [0:DATA_WIDTH-1] w,
                                                         input int nb);
        logic [0:DATA_WIDTH-1] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < nb) r[k*SYMBOL_WIDTH +: SYMBOL_WIDTH] = w[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
        return r;
    endfunction

    assign accept     = i_valid && o_in_ready_q;
    assign eot_n      = int'(i_eot_bytes);
    assign strip_word = {hold_q, i_data[0:DATA_WIDTH-HW-1]};
    assign sot_word   = {i_data[HW:DATA_WIDTH-1], {HW{1'b0}}};
    assign flush_word = keep_bytes({hold_q, {(DATA_WIDTH-HW){1'b0}}}, int'(flush_n_q));

    rx_deframe_hold_reg #(.SYMBOL_WIDTH(SYMBOL_WIDTH)) u_hold (
        .clk_i  (CLK),
        .rst_ni (RST_L),
        .we_i   (hold_we),
        .d_i    (i_data[DATA_WIDTH-HW:DATA_WIDTH-1]),
        .q_o    (hold_q)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q       <= IDLE;
            sot_pend_q    <= 1'b0;
            flush_n_q     <= '0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_sot_q       <= 1'b0;
            o_eot_q       <= 1'b0;
            o_eot_bytes_q <= '0;
            o_frm_err_q   <= 1'b0;
            o_in_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            sot_pend_q    <= sot_pend_d;
            flush_n_q     <= flush_n_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            o_sot_q       <= o_sot_d;
            o_eot_q       <= o_eot_d;
            o_eot_bytes_q <= o_eot_bytes_d;
            o_frm_err_q   <= frm_err_d | len_err;
            o_in_ready_q  <= o_in_ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sot_pend_d    = sot_pend_q;
        flush_n_d     = flush_n_q;
        hold_we       = 1'b0;
        o_valid_d     = 1'b0;
        o_data_d      = o_data_q;
        o_sot_d       = 1'b0;
        o_eot_d       = 1'b0;
        o_eot_bytes_d = '0;
        frm_err_d     = 1'b0;
        o_in_ready_d  = 1'b1;
        if (state_q == FLUSH) begin
            o_valid_d     = 1'b1;
            o_eot_d       = 1'b1;
            o_data_d      = flush_word;
            o_eot_bytes_d = flush_n_q;
            state_d       = IDLE;
        end else if (accept && i_sot) begin
            // A SOT inside an open TLP abandons it; the new token is handled as from IDLE
            frm_err_d  = (state_q == STRIP);
            sot_pend_d = 1'b0;
            state_d    = IDLE;
            if (i_eot) begin
                if (eot_n <= TOKEN_BYTES) begin
                    frm_err_d = 1'b1;
                end else begin
                    o_valid_d     = 1'b1;
                    o_sot_d       = 1'b1;
                    o_eot_d       = 1'b1;
                    o_data_d      = keep_bytes(sot_word, eot_n - TOKEN_BYTES);
                    o_eot_bytes_d = CNT_WIDTH'(eot_n - TOKEN_BYTES);
                end
            end else begin
                hold_we    = 1'b1;
                sot_pend_d = 1'b1;
                state_d    = STRIP;
            end
        end else if (accept && state_q == STRIP) begin
            o_valid_d  = 1'b1;
            o_sot_d    = sot_pend_q;
            sot_pend_d = 1'b0;
            hold_we    = 1'b1;
            o_data_d   = strip_word;
            if (i_eot) begin
                if (eot_n <= LANES - TOKEN_BYTES) begin
                    o_eot_d       = 1'b1;
                    o_data_d      = keep_bytes(strip_word, eot_n + TOKEN_BYTES);
                    o_eot_bytes_d = CNT_WIDTH'(eot_n + TOKEN_BYTES);
                    state_d       = IDLE;
                end else begin
                    // Residue still sits in the holding register; emit it next cycle
                    flush_n_d    = CNT_WIDTH'(eot_n - (LANES - TOKEN_BYTES));
                    o_in_ready_d = 1'b0;
                    state_d      = FLUSH;
                end
            end
        end
    end

`ifdef RX_DEFRAME_LEN_CHK_EN
    logic [TOK_LEN_W-1:0] len_q, len_d, len_ref;
    logic [15:0]          cnt_q, cnt_d, cnt_tot;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        len_ref = len_q;
        len_err = 1'b0;
        cnt_tot = (o_sot_d ? 16'd0 : cnt_q)
                + (o_eot_d ? 16'(o_eot_bytes_d) : 16'(LANES));
        if (state_q != FLUSH && accept && i_sot) begin
            len_d   = i_data[TOK_LEN_LO:TOK_LEN_HI];
            len_ref = i_data[TOK_LEN_LO:TOK_LEN_HI];
            cnt_d   = '0;
        end
        if (o_valid_d) begin
            cnt_d   = cnt_tot;
            len_err = o_eot_d && (cnt_tot != 16'({len_ref, 2'b00}));
        end
    end
`else
    assign len_err = 1'b0;
`endif

    assign o_in_ready  = o_in_ready_q;
    assign o_valid     = o_valid_q;
    assign o_data      = o_data_q;
    assign o_sot       = o_sot_q;
    assign o_eot       = o_eot_q;
    assign o_eot_bytes = o_eot_bytes_q;
    assign o_frm_err   = o_frm_err_q;

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - directed self-checking bench for rx_deframer (LANES=4)
module tb_rx_deframer;

    logic        CLK = 1'b0;
    logic        RST_L = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_in_ready;
    logic [0:31] i_data = '0;
    logic        i_sot = 1'b0;
    logic        i_eot = 1'b0;
    logic [2:0]  i_eot_bytes = '0;
    logic        o_valid;
    logic [0:31] o_data;
    logic        o_sot;
    logic        o_eot;
    logic [2:0]  o_eot_bytes;
    logic        o_frm_err;

    int n_tests = 0;
    int n_fail  = 0;

    rx_deframer dut (
        .CLK         (CLK),
        .RST_L       (RST_L),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_data      (i_data),
        .i_sot       (i_sot),
        .i_eot       (i_eot),
        .i_eot_bytes (i_eot_bytes),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_sot       (o_sot),
        .o_eot       (o_eot),
        .o_eot_bytes (o_eot_bytes),
        .o_frm_err   (o_frm_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one beat for the next posedge, returns at the following negedge
    task automatic send(input logic sot, input logic eot, input int nb, input logic [31:0] d);
        i_valid     = 1'b1;
        i_sot       = sot;
        i_eot       = eot;
        i_eot_bytes = 3'(nb);
        i_data      = d;
        @(posedge CLK);
        @(negedge CLK);
        i_valid = 1'b0;
        i_sot   = 1'b0;
        i_eot   = 1'b0;
    endtask

    task automatic idle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // valid, sot, eot, eot_bytes, frm_err, data
    task automatic expect_out(input string tag, input logic v, input logic s, input logic e,
                              input int nb, input logic fe, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".frm_err"}, 32'(o_frm_err), 32'(fe));
        if (v) begin
            chk({tag, ".sot"}, 32'(o_sot), 32'(s));
            chk({tag, ".eot"}, 32'(o_eot), 32'(e));
            chk({tag, ".data"}, o_data, d);
            if (e) chk({tag, ".eot_bytes"}, 32'(o_eot_bytes), 32'(nb));
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_in_ready), 32'd1);
        chk("rst.data", o_data, 32'h0);
        chk("rst.eotb", 32'(o_eot_bytes), 32'd0);
        chk("rst.err", 32'(o_frm_err), 32'd0);
        RST_L = 1'b1;
        idle();

        // Two-word TLP with FLUSH
        send(1, 0, 4, 32'hF0F1_0A0B);
        expect_out("tw.sot", 0, 0, 0, 0, 0, 32'h0);
        send(0, 1, 4, 32'h0C0D_0E0F);
        expect_out("tw.w0", 1, 1, 0, 0, 0, 32'h0A0B_0C0D);
        chk("tw.ready0", 32'(o_in_ready), 32'd0);
        idle();
        expect_out("tw.flush", 1, 0, 1, 2, 0, 32'h0E0F_0000);
        chk("tw.ready1", 32'(o_in_ready), 32'd1);

        // Single-word TLP
        send(1, 1, 4, 32'hF0F1_A1B1);
        expect_out("sw", 1, 1, 1, 2, 0, 32'hA1B1_0000);

        // Short tail, junk in unused bytes must be zeroed
        send(1, 0, 4, 32'hF0F1_A2B2);
        send(0, 1, 2, 32'hC2D2_9999);
        expect_out("st", 1, 1, 1, 4, 0, 32'hA2B2_C2D2);
        idle();
        expect_out("st.after", 0, 0, 0, 0, 0, 32'h0);
        chk("st.ready", 32'(o_in_ready), 32'd1);

        // SOT in the middle of a TLP
        send(1, 0, 4, 32'hF0F1_A3B3);
        send(0, 0, 4, 32'hC3D3_E3F3);
        expect_out("mid.w0", 1, 1, 0, 0, 0, 32'hA3B3_C3D3);
        send(1, 0, 4, 32'hF0F1_A4B4);
        expect_out("mid.err", 0, 0, 0, 0, 1, 32'h0);
        send(0, 1, 2, 32'hC4D4_0000);
        expect_out("mid.new", 1, 1, 1, 4, 0, 32'hA4B4_C4D4);

        // Gap inside TLP, then EOT with n=LANES-1 giving a 1-byte flush
        send(1, 0, 4, 32'hF0F1_A5B5);
        send(0, 0, 4, 32'hC5D5_E5F5);
        expect_out("gap.w0", 1, 1, 0, 0, 0, 32'hA5B5_C5D5);
        idle();
        expect_out("gap.stall", 0, 0, 0, 0, 0, 32'h0);
        chk("gap.hold", o_data, 32'hA5B5_C5D5);
        send(0, 1, 3, 32'h1122_3344);
        expect_out("gap.w1", 1, 0, 0, 0, 0, 32'hE5F5_1122);
        idle();
        expect_out("gap.flush", 1, 0, 1, 1, 0, 32'h3300_0000);

        // Reset mid-STRIP
        send(1, 0, 4, 32'hF0F1_A6B6);
        send(0, 0, 4, 32'hC6D6_E6F6);
        expect_out("rs.w0", 1, 1, 0, 0, 0, 32'hA6B6_C6D6);
        RST_L = 1'b0;
        #1;
        chk("rs.valid", 32'(o_valid), 32'd0);
        chk("rs.data", o_data, 32'h0);
        chk("rs.ready", 32'(o_in_ready), 32'd1);
        chk("rs.sot", 32'(o_sot), 32'd0);
        @(negedge CLK);
        RST_L = 1'b1;
        send(0, 1, 2, 32'hDEAD_BEEF);
        expect_out("rs.drop", 0, 0, 0, 0, 0, 32'h0);
        send(1, 0, 4, 32'hF0F1_A8B8);
        send(0, 1, 2, 32'hC8D8_0000);
        expect_out("rs.new", 1, 1, 1, 4, 0, 32'hA8B8_C8D8);

        // Short single-word TLPs: 1 payload byte, and a token-only word
        send(1, 1, 3, 32'hF0F1_A7B7);
        expect_out("sw1", 1, 1, 1, 1, 0, 32'hA700_0000);
        send(1, 1, 2, 32'hF0F1_0000);
        expect_out("sw0", 0, 0, 0, 0, 1, 32'h0);
        idle();
        expect_out("sw0.after", 0, 0, 0, 0, 0, 32'h0);

`ifdef RX_DEFRAME_LEN_CHK_EN
        // len=1 DW but 8 payload bytes
        send(1, 0, 4, 32'h0002_A9B9);
        send(0, 0, 4, 32'hC9D9_E9F9);
        expect_out("len.w0", 1, 1, 0, 0, 0, 32'hA9B9_C9D9);
        send(0, 1, 2, 32'h1213_0000);
        expect_out("len.bad", 1, 0, 1, 4, 1, 32'hE9F9_1213);
        // len=1 DW with 4 payload bytes
        send(1, 0, 4, 32'h0002_AABA);
        send(0, 1, 2, 32'hCADA_0000);
        expect_out("len.ok", 1, 1, 1, 4, 0, 32'hAABA_CADA);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
